// File: rtl/boot_pkg.sv
// boot_pkg: shared FSM states, header magic and header field positions for the boot loader
package boot_pkg;
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_HDR_RD   = 4'd1,
    ST_HDR_CHK  = 4'd2,
    ST_DAT_WAIT = 4'd3,
    ST_DAT_RD   = 4'd4,
    ST_DAT_CAP  = 4'd5,
    ST_DAT_WR   = 4'd6,
    ST_DONE     = 4'd7,
    ST_ERROR    = 4'd8
  } state_t;
  localparam logic [7:0] MAGIC       = 8'hAD;
  localparam int         HDR_CNT_MSB = 31;
  localparam int         HDR_CNT_LSB = 16;
  localparam int         HDR_MAG_MSB = 15;
  localparam int         HDR_MAG_LSB = 8;
endpackage

// File: rtl/boot_loader.sv
// boot_loader: pops a header and N payload words from the boot FIFO and writes them to instruction memory
module boot_loader #(
  parameter int               DATA_W    = 32,
  parameter int               ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [7:0]       MAGIC     = boot_pkg::MAGIC
) (
  input  logic              bootld_clk_i,
  input  logic              bootld_rst_i,
  input  logic              bootld_start_i,
  input  logic              bootld_fifo_empty_i,
  output logic              bootld_fifo_rd_o,
  input  logic [DATA_W-1:0] bootld_fifo_data_i,
  output logic              bootld_mem_we_o,
  output logic [ADDR_W-1:0] bootld_mem_addr_o,
  output logic [DATA_W-1:0] bootld_mem_wdata_o,
  input  logic              bootld_mem_ready_i,
  output logic              bootld_busy_o,
  output logic              bootld_done_o,
  output logic              bootld_error_o,
  output logic [DATA_W-1:0] bootld_checksum_o,
  output logic [15:0]       bootld_count_o
);
  import boot_pkg::*;
  // Largest word count that still fits between BASE_ADDR and the top of the address space
  localparam int LIMIT = 2 ** (ADDR_W - 2) - int'(BASE_ADDR) / 4;
  state_t              r_state;
  logic [15:0]         r_remaining;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_done;
  logic                r_error;
  logic [DATA_W-1:0]   r_checksum;
  logic [15:0]         r_count;
  logic [15:0]         w_hdr_cnt;
  logic [7:0]          w_hdr_mag;
  logic                w_hdr_bad;
  logic                w_idle;
  assign w_hdr_cnt = bootld_fifo_data_i[HDR_CNT_MSB:HDR_CNT_LSB];
  assign w_hdr_mag = bootld_fifo_data_i[HDR_MAG_MSB:HDR_MAG_LSB];
  assign w_hdr_bad = (w_hdr_mag != MAGIC) || (int'(w_hdr_cnt) > LIMIT);
  assign w_idle    = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
  // Pop only from the two read states and never while the FIFO is empty
  always_comb begin
    bootld_fifo_rd_o = ((r_state == ST_HDR_RD) || (r_state == ST_DAT_WAIT)) && !bootld_fifo_empty_i;
    bootld_busy_o    = !w_idle;
  end
  assign bootld_mem_we_o    = r_we;
  assign bootld_mem_addr_o  = r_addr;
  assign bootld_mem_wdata_o = r_wdata;
  assign bootld_done_o      = r_done;
  assign bootld_error_o     = r_error;
  assign bootld_checksum_o  = r_checksum;
  assign bootld_count_o     = r_count;
  // Load FSM: header check, then one word in flight at a time through capture and write
  always_ff @(posedge bootld_clk_i or negedge bootld_rst_i) begin
    if (!bootld_rst_i) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_checksum  <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: if (bootld_start_i) begin
          r_done      <= 1'b0;
          r_error     <= 1'b0;
          r_checksum  <= '0;
          r_count     <= '0;
          r_remaining <= '0;
          r_addr      <= BASE_ADDR;
          r_state     <= ST_HDR_RD;
        end
        ST_HDR_RD: if (!bootld_fifo_empty_i) r_state <= ST_HDR_CHK;
        ST_HDR_CHK: begin
          if (w_hdr_bad) begin
            r_error <= 1'b1;
            r_state <= ST_ERROR;
          end else if (w_hdr_cnt == 16'd0) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_remaining <= w_hdr_cnt;
            r_state     <= ST_DAT_WAIT;
          end
        end
        ST_DAT_WAIT: if (!bootld_fifo_empty_i) r_state <= ST_DAT_RD;
        ST_DAT_RD: r_state <= ST_DAT_CAP;
        ST_DAT_CAP: begin
          r_wdata <= bootld_fifo_data_i;
          r_we    <= 1'b1;
          r_state <= ST_DAT_WR;
        end
        ST_DAT_WR: if (bootld_mem_ready_i) begin
          r_we        <= 1'b0;
          r_addr      <= r_addr + ADDR_W'(4);
          r_checksum  <= r_checksum ^ r_wdata;
          r_count     <= r_count + 16'd1;
          r_remaining <= r_remaining - 16'd1;
          r_done      <= (r_remaining == 16'd1);
          r_state     <= (r_remaining == 16'd1) ? ST_DONE : ST_DAT_WAIT;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed tests of the boot loader against a FIFO and memory model
module tb_boot_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        empty, rd, we, ready, busy, done, error;
  logic [31:0] fdata = '0;
  logic [31:0] wdata, chk;
  logic [15:0] addr, count;
  logic [31:0] q[$];
  int          rp = 0;
  int          gap = 0, gap_cfg = 0;
  int          bp = 0, bp_cfg = 0;
  int          rd_n = 0, rd_empty_n = 0, we_n = 0, wait_n = 0, unstable_n = 0;
  logic [15:0] w_addr[$];
  logic [31:0] w_data[$];
  logic        p_wait = 1'b0;
  logic [15:0] p_addr = '0;
  logic [31:0] p_wdata = '0;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  boot_loader dut (
    .bootld_clk_i(clk), .bootld_rst_i(rst_n), .bootld_start_i(start),
    .bootld_fifo_empty_i(empty), .bootld_fifo_rd_o(rd), .bootld_fifo_data_i(fdata),
    .bootld_mem_we_o(we), .bootld_mem_addr_o(addr), .bootld_mem_wdata_o(wdata),
    .bootld_mem_ready_i(ready), .bootld_busy_o(busy), .bootld_done_o(done),
    .bootld_error_o(error), .bootld_checksum_o(chk), .bootld_count_o(count)
  );

  assign empty = (rp >= q.size()) || (gap > 0);
  assign ready = (bp_cfg == 0) ? 1'b1 : (bp_cfg == 1) ? (bp >= 3) : 1'b0;

  // FIFO and memory model plus protocol monitor
  always @(posedge clk) begin
    if (rd) begin
      rd_n++;
      if (empty) rd_empty_n++;
      else begin
        fdata <= q[rp];
        rp    <= rp + 1;
        gap   <= gap_cfg;
      end
    end else if (gap > 0) gap <= gap - 1;
    if (we && ready) begin
      we_n++;
      w_addr.push_back(addr);
      w_data.push_back(wdata);
      bp <= 0;
    end else if (we) begin
      wait_n++;
      bp <= bp + 1;
    end
    if (p_wait && we && (addr !== p_addr || wdata !== p_wdata)) unstable_n++;
    p_wait  <= we && !ready;
    p_addr  <= addr;
    p_wdata <= wdata;
  end

  task automatic clear_mon();
    rd_n = 0; rd_empty_n = 0; we_n = 0; wait_n = 0; unstable_n = 0;
    w_addr.delete(); w_data.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int i;
    for (i = 0; i < 600; i++) begin
      if (done || error) break;
      @(negedge clk);
    end
    if (i == 600) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: done=%0b error=%0b after %0d cycles, required done or error", name, done, error, i);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_nominal(input string name);
    logic [31:0] exp_d[4] = '{32'd1, 32'd2, 32'd3, 32'd5};
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL %s done: got %0b want 1", name, done); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL %s error: got %0b want 0", name, error); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy: got %0b want 0", name, busy); end
    n_cmp++; if (count !== 16'd4) begin n_bad++; $display("FAIL %s count: got %0d want 4", name, count); end
    n_cmp++; if (chk !== 32'h5) begin n_bad++; $display("FAIL %s checksum: got %h want 00000005", name, chk); end
    n_cmp++; if (rd_n !== 5) begin n_bad++; $display("FAIL %s rd pulses: got %0d want 5", name, rd_n); end
    n_cmp++; if (w_addr.size() !== 4) begin n_bad++; $display("FAIL %s writes: got %0d want 4", name, w_addr.size()); end
    for (int i = 0; i < 4 && i < w_addr.size(); i++) begin
      n_cmp++;
      if (w_addr[i] !== 16'(4 * i) || w_data[i] !== exp_d[i]) begin
        n_bad++;
        $display("FAIL %s write%0d: got %h@%h want %h@%h", name, i, w_data[i], w_addr[i], exp_d[i], 16'(4 * i));
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rd, we, busy, done, error} !== 5'b0 || addr !== 16'h0 || wdata !== 32'h0 || chk !== 32'h0 || count !== 16'h0) begin
      n_bad++;
      $display("FAIL reset outputs: rd=%b we=%b busy=%b done=%b err=%b addr=%h wdata=%h chk=%h cnt=%h want all 0",
               rd, we, busy, done, error, addr, wdata, chk, count);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    q = '{32'h0004AD00, 32'd1, 32'd2, 32'd3, 32'd5}; rp = 0; gap_cfg = 0; bp_cfg = 0;
    clear_mon();
    pulse_start();
    wait_end("nominal");
    check_nominal("nominal");
    n_cmp++; if (wait_n !== 0) begin n_bad++; $display("FAIL nominal wait cycles: got %0d want 0", wait_n); end
  endtask

  task automatic test_bad_magic();
    q = '{32'h0004AB00, 32'd1, 32'd2, 32'd3, 32'd5}; rp = 0;
    clear_mon();
    pulse_start();
    wait_end("bad_magic");
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL bad_magic error: got %0b want 1", error); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL bad_magic done: got %0b want 0", done); end
    n_cmp++; if (rd_n !== 1) begin n_bad++; $display("FAIL bad_magic rd pulses: got %0d want 1", rd_n); end
    n_cmp++; if (we_n !== 0) begin n_bad++; $display("FAIL bad_magic writes: got %0d want 0", we_n); end
    n_cmp++; if (q.size() - rp !== 4) begin n_bad++; $display("FAIL bad_magic fifo left: got %0d want 4", q.size() - rp); end
  endtask

  task automatic test_overflow();
    q = '{32'h4001AD00}; rp = 0;
    clear_mon();
    pulse_start();
    wait_end("overflow");
    n_cmp++; if (error !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL overflow flags: got err=%0b done=%0b want err=1 done=0", error, done); end
  endtask

  task automatic test_zero_count();
    q = '{32'h0000AD00}; rp = 0;
    clear_mon();
    pulse_start();
    wait_end("zero");
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero done: got %0b want 1", done); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL zero error: got %0b want 0", error); end
    n_cmp++; if (count !== 16'd0) begin n_bad++; $display("FAIL zero count: got %0d want 0", count); end
    n_cmp++; if (we_n !== 0) begin n_bad++; $display("FAIL zero writes: got %0d want 0", we_n); end
  endtask

  task automatic test_backpressure();
    q = '{32'h0004AD00, 32'd1, 32'd2, 32'd3, 32'd5}; rp = 0; gap_cfg = 5; bp_cfg = 1;
    clear_mon();
    pulse_start();
    wait_end("backpressure");
    check_nominal("backpressure");
    n_cmp++; if (wait_n !== 12) begin n_bad++; $display("FAIL backpressure wait cycles: got %0d want 12", wait_n); end
    n_cmp++; if (unstable_n !== 0) begin n_bad++; $display("FAIL backpressure stability: got %0d changes want 0", unstable_n); end
    n_cmp++; if (rd_empty_n !== 0) begin n_bad++; $display("FAIL backpressure rd while empty: got %0d want 0", rd_empty_n); end
    gap_cfg = 0; bp_cfg = 0;
  endtask

  task automatic test_restart();
    q = '{32'h0001AD00, 32'hDEADBEEF}; rp = 0;
    clear_mon();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL restart done before: got %0b want 1", done); end
    pulse_start();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL restart clear: got done=%0b busy=%0b want done=0 busy=1", done, busy); end
    wait_end("restart");
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL restart done after: got %0b want 1", done); end
    n_cmp++; if (chk !== 32'hDEADBEEF) begin n_bad++; $display("FAIL restart checksum: got %h want deadbeef", chk); end
    n_cmp++; if (count !== 16'd1) begin n_bad++; $display("FAIL restart count: got %0d want 1", count); end
    n_cmp++;
    if (w_addr.size() !== 1 || w_addr[0] !== 16'h0 || w_data[0] !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL restart write: got %0d writes, first %h@%h want deadbeef@0000", w_addr.size(), w_data[0], w_addr[0]);
    end
  endtask

  task automatic test_reset_mid();
    int i;
    q = '{32'h0001AD00, 32'h00001234}; rp = 0; bp_cfg = 2;
    clear_mon();
    pulse_start();
    for (i = 0; i < 50 && !we; i++) @(negedge clk);
    n_cmp++; if (we !== 1'b1) begin n_bad++; $display("FAIL reset_mid reach write: we=%0b want 1", we); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL reset_mid async we: got %0b want 0", we); end
    @(negedge clk);
    n_cmp++;
    if ({rd, we, busy, done, error} !== 5'b0 || addr !== 16'h0 || wdata !== 32'h0 || chk !== 32'h0 || count !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_mid outputs: rd=%b we=%b busy=%b done=%b err=%b addr=%h wdata=%h chk=%h cnt=%h want all 0",
               rd, we, busy, done, error, addr, wdata, chk, count);
    end
    rst_n = 1'b1; bp_cfg = 0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid idle after release: busy=%0b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_magic();
    test_overflow();
    test_zero_count();
    test_backpressure();
    test_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
